axis_packet_router: RTL
=======================

// Module: axis_packet_router
//
// PURPOSE
//   Packet-aware successor to the single-output stream gate. Routes one AXI-Stream input to one
//   of NUM_OUTPUTS outputs. Enable and output select are sampled only at packet boundaries
//   (TLAST), so a packet is never split or truncated. Disabled packets are either backpressured
//   or drained, selected by parameter. Saturating packet counters give status visibility.
//   Sits between the packet source and downstream consumers (DMA / network TX paths).
//
// PARAMETERS
//   DATA_WIDTH   256  TDATA width in bits
//   NUM_OUTPUTS  2    number of output streams, 1..8
//   SEL_WIDTH    3    width of OUT_SELECT; must satisfy 2**SEL_WIDTH >= NUM_OUTPUTS
//   DRAIN_MODE   0    0 = disabled packet is held off (TREADY=0); 1 = disabled packet is accepted and discarded
//   COUNT_WIDTH  32   width of the status counters
//
// PORTS
//   clk             in   1                        clock; all logic on rising edge
//   reset           in   1                        asynchronous, active-high reset
//   ENABLE_STREAM   in   1                        routing enable, sampled at packet start
//   OUT_SELECT      in   SEL_WIDTH                output index, sampled at packet start
//   AXIS_RX_TDATA   in   DATA_WIDTH               input data
//   AXIS_RX_TVALID  in   1                        input valid
//   AXIS_RX_TLAST   in   1                        input end-of-packet
//   AXIS_RX_TREADY  out  1                        input ready
//   AXIS_TX_TDATA   out  NUM_OUTPUTS*DATA_WIDTH   output data; output i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
//   AXIS_TX_TVALID  out  NUM_OUTPUTS              per-output valid
//   AXIS_TX_TLAST   out  NUM_OUTPUTS              per-output end-of-packet
//   AXIS_TX_TREADY  in   NUM_OUTPUTS              per-output ready
//   BUSY            out  1                        1 while a multi-beat packet is in progress (state != IDLE)
//   PKT_FWD_COUNT   out  COUNT_WIDTH              packets delivered (TLAST handshakes on any output)
//   PKT_DROP_COUNT  out  COUNT_WIDTH              packets discarded (DRAIN_MODE=1 only; otherwise stays 0)
//
// BEHAVIOUR
//   - Reset (async assert): state=IDLE, route=0, both counters=0, BUSY=0. While reset is high,
//     AXIS_RX_TREADY=0 and all AXIS_TX_TVALID=0. Reset mid-packet abandons that packet. The
//     next beat accepted after reset is treated as a packet start.
//   - Datapath is combinational, with zero cycles of latency. TDATA is broadcast to every
//     output slice. Only the routed slice may assert TVALID/TLAST. Non-routed slices have
//     TVALID=0 and TLAST=0.
//   - A beat is accepted when RX_TVALID && RX_TREADY.
//   - A route is "enabled" when ENABLE_STREAM==1 and OUT_SELECT < NUM_OUTPUTS. Otherwise it is disabled.
//   - State machine has three states:
//     IDLE: the decision uses the live ENABLE_STREAM/OUT_SELECT.
//       * Enabled: TX_TVALID[OUT_SELECT]=RX_TVALID, RX_TREADY=TX_TREADY[OUT_SELECT].
//         An accepted beat with TLAST=0 latches route<=OUT_SELECT and moves to FORWARD.
//       * Disabled, DRAIN_MODE=0: RX_TREADY=0, no TX valid, stay in IDLE.
//       * Disabled, DRAIN_MODE=1: RX_TREADY=1, no TX valid. An accepted beat with TLAST=0
//         moves to DISCARD.
//       * An accepted beat with TLAST=1 (single-beat packet) stays in IDLE and bumps the
//         matching counter.
//     FORWARD: uses the latched route. ENABLE_STREAM/OUT_SELECT are ignored.
//       TX_TVALID[route]=RX_TVALID, RX_TREADY=TX_TREADY[route]. An accepted TLAST returns to
//       IDLE and increments PKT_FWD_COUNT.
//     DISCARD: RX_TREADY=1, no TX valid. An accepted TLAST returns to IDLE and increments PKT_DROP_COUNT.
//   - Handshake rules: RX_TREADY may depend on TX_TREADY combinationally. TX_TVALID never
//     depends on TX_TREADY. Holding rules follow AXI-Stream, because the upstream holds data
//     while RX_TREADY=0.
//   - Counters saturate at all-ones; they never wrap. Each counter increments by at most one per cycle.
//   - Select changes in the same cycle as the TLAST handshake apply to the next beat, which is the next packet start.
//
// TESTING
//   1. Reset: assert reset mid-stream -> RX_TREADY=0, TX_TVALID=0, counters=0, BUSY=0 with no clock edge needed.
//   2. NUM_OUTPUTS=4, sel=2, enabled, 4-beat packet with sel changed to 1 after beat 1 ->
//      all 4 beats appear on output 2 only; PKT_FWD_COUNT=1.
//   3. Hold TX_TREADY[2]=0 for 5 cycles mid-packet -> RX_TREADY=0 for those cycles, no beat
//      lost or duplicated, and output 2 data matches input order.
//   4. DRAIN_MODE=0, ENABLE_STREAM=0 -> RX_TREADY=0 indefinitely. Raise enable -> the held
//      packet is forwarded intact.
//   5. DRAIN_MODE=1, OUT_SELECT=5 with NUM_OUTPUTS=4, 3-beat packet -> RX_TREADY=1, no TX
//      valid, PKT_DROP_COUNT=1. A following 1-beat packet with sel=0 appears on output 0.
//   6. COUNT_WIDTH=4, send 17 single-beat packets back-to-back -> PKT_FWD_COUNT saturates at 15.

Source files
------------

// File: rtl/axis_packet_router.sv
// Packet-aware AXI-Stream router: one input to NUM_OUTPUTS outputs, route chosen at packet start.
// Zero-cycle combinational datapath; RX ready follows the routed TX ready, or is forced high/low for disabled packets by DRAIN_MODE.
module axis_packet_router #(
    parameter int DATA_WIDTH  = 256,
    parameter int NUM_OUTPUTS = 2,
    parameter int SEL_WIDTH   = 3,
    parameter int DRAIN_MODE  = 0,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ENABLE_STREAM,
    input  logic [SEL_WIDTH-1:0]              OUT_SELECT,
    input  logic [DATA_WIDTH-1:0]             AXIS_RX_TDATA,
    input  logic                              AXIS_RX_TVALID,
    input  logic                              AXIS_RX_TLAST,
    output logic                              AXIS_RX_TREADY,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] AXIS_TX_TDATA,
    output logic [NUM_OUTPUTS-1:0]            AXIS_TX_TVALID,
    output logic [NUM_OUTPUTS-1:0]            AXIS_TX_TLAST,
    input  logic [NUM_OUTPUTS-1:0]            AXIS_TX_TREADY,
    output logic                              BUSY,
    output logic [COUNT_WIDTH-1:0]            PKT_FWD_COUNT,
    output logic [COUNT_WIDTH-1:0]            PKT_DROP_COUNT
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FORWARD = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    localparam logic [SEL_WIDTH:0] LP_NUM_OUT = NUM_OUTPUTS[SEL_WIDTH:0];

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SEL_WIDTH-1:0]   r_route;
    logic [COUNT_WIDTH-1:0] r_fwd_cnt;
    logic [COUNT_WIDTH-1:0] r_drop_cnt;

    logic                   w_route_ok;
    logic                   w_fwd;
    logic                   w_drain;
    logic [SEL_WIDTH-1:0]   w_idx;
    logic                   w_rx_rdy;
    logic [NUM_OUTPUTS-1:0] w_tx_vld;
    logic [NUM_OUTPUTS-1:0] w_tx_last;
    logic                   w_acc;
    logic                   w_latch_route;
    logic                   w_fwd_inc;
    logic                   w_drop_inc;

    assign w_route_ok = ENABLE_STREAM && ({1'b0, OUT_SELECT} < LP_NUM_OUT);

    always_comb begin
        w_fwd         = 1'b0;
        w_drain       = 1'b0;
        w_idx         = r_route;
        w_rx_rdy      = 1'b0;
        w_tx_vld      = '0;
        w_tx_last     = '0;
        w_state_nxt   = r_state;
        w_latch_route = 1'b0;
        w_fwd_inc     = 1'b0;
        w_drop_inc    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_route_ok) begin
                    w_fwd = 1'b1;
                    w_idx = OUT_SELECT;
                end else if (DRAIN_MODE != 0) begin
                    w_drain = 1'b1;
                end
            end
            S_FORWARD: w_fwd   = 1'b1;
            S_DISCARD: w_drain = 1'b1;
            default:   w_drain = 1'b0;
        endcase

        // Compare against each legal index so an out-of-range select never reaches a bit-select.
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (w_fwd && (w_idx == SEL_WIDTH'(i))) begin
                w_tx_vld[i]  = AXIS_RX_TVALID;
                w_tx_last[i] = AXIS_RX_TLAST;
                w_rx_rdy     = AXIS_TX_TREADY[i];
            end
        end
        if (w_drain) begin
            w_rx_rdy = 1'b1;
        end

        w_acc = AXIS_RX_TVALID && w_rx_rdy;

        if (w_acc) begin
            if (AXIS_RX_TLAST) begin
                w_state_nxt = S_IDLE;
                w_fwd_inc   = w_fwd;
                w_drop_inc  = w_drain;
            end else if (r_state == S_IDLE) begin
                w_state_nxt   = w_fwd ? S_FORWARD : S_DISCARD;
                w_latch_route = w_fwd;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_route    <= '0;
            r_fwd_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch_route) begin
                r_route <= OUT_SELECT;
            end
            if (w_fwd_inc && (r_fwd_cnt != '1)) begin
                r_fwd_cnt <= r_fwd_cnt + 1'b1;
            end
            if (w_drop_inc && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // Handshake outputs are forced idle while reset is held, independent of the clock.
    assign AXIS_RX_TREADY = w_rx_rdy && !reset;
    assign AXIS_TX_TVALID = reset ? '0 : w_tx_vld;
    assign AXIS_TX_TLAST  = reset ? '0 : w_tx_last;
    assign AXIS_TX_TDATA  = {NUM_OUTPUTS{AXIS_RX_TDATA}};
    assign BUSY           = (r_state != S_IDLE);
    assign PKT_FWD_COUNT  = r_fwd_cnt;
    assign PKT_DROP_COUNT = r_drop_cnt;

endmodule
